// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM state codes, opcode
// values, opcode classes, ALU operation codes, mux select encodings and the
// bundle of single-bit control strobes.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_ALU_WB   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CL_R       = 3'd0,
        CL_I       = 3'd1,
        CL_MEM     = 3'd2,
        CL_BR      = 3'd3,
        CL_J       = 3'd4,
        CL_ILLEGAL = 3'd5
    } opclass_t;

    // Opcode values (cast to the opcode width at the point of use)
    localparam int OP_J    = 1;
    localparam int OP_MOV  = 16;
    localparam int OP_NOT  = 17;
    localparam int OP_ADD  = 18;
    localparam int OP_SUB  = 19;
    localparam int OP_OR   = 20;
    localparam int OP_AND  = 21;
    localparam int OP_SLT  = 23;
    localparam int OP_BEQ  = 32;
    localparam int OP_BNE  = 33;
    localparam int OP_ADDI = 50;
    localparam int OP_SUBI = 51;
    localparam int OP_ORI  = 52;
    localparam int OP_ANDI = 53;
    localparam int OP_SLTI = 55;
    localparam int OP_LI   = 57;
    localparam int OP_LWI  = 59;
    localparam int OP_SWI  = 60;

    // ALU operation codes
    localparam logic [3:0] ALU_MOV = 4'd0;
    localparam logic [3:0] ALU_NOT = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd7;

    // PCSrc encodings
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_BROFF = 2'd3;

    // Every control output except ALUOP (whose width is a parameter)
    typedef struct packed {
        logic       pcwritecond;
        logic       pcwrite;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       beq;
        logic       alusrca;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic       illegal;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. The controller is the master: it drives the
// control strobes, state and counters, and receives the opcode and mem_ready.
interface multicycle_controller_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] OPcode;
    logic                mem_ready;

    logic                PCWriteCond;
    logic                PCWrite;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                MemtoReg;
    logic                IRWrite;
    logic                BEQ;
    logic                ALUSrcA;
    logic                RegWrite;
    logic                RegDst;
    logic [1:0]          PCSrc;
    logic [ALUOP_W-1:0]  ALUOP;
    logic [1:0]          ALUSrcB;
    logic [3:0]          state;
    logic                illegal;
    logic                instr_done;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        input  OPcode, mem_ready,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, BEQ, ALUSrcA, RegWrite, RegDst, PCSrc, ALUOP,
               ALUSrcB, state, illegal, instr_done, instr_count
    );

    modport slave (
        output OPcode, mem_ready,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, BEQ, ALUSrcA, RegWrite, RegDst, PCSrc, ALUOP,
               ALUSrcB, state, illegal, instr_done, instr_count
    );
endinterface

// File: rtl/mc_opclass.sv
// Combinational opcode classifier: maps an opcode onto the instruction class
// that selects the post-DECODE state. Unlisted opcodes are illegal.
module mc_opclass
    import mc_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output opclass_t            opclass
);

    // Full-width compare so that wider opcodes never alias onto legal ones
    always_comb begin
        opclass = CL_ILLEGAL;
        case (opcode)
            OPCODE_W'(OP_J):    opclass = CL_J;
            OPCODE_W'(OP_MOV),
            OPCODE_W'(OP_NOT),
            OPCODE_W'(OP_ADD),
            OPCODE_W'(OP_SUB),
            OPCODE_W'(OP_OR),
            OPCODE_W'(OP_AND),
            OPCODE_W'(OP_SLT):  opclass = CL_R;
            OPCODE_W'(OP_BEQ),
            OPCODE_W'(OP_BNE):  opclass = CL_BR;
            OPCODE_W'(OP_ADDI),
            OPCODE_W'(OP_SUBI),
            OPCODE_W'(OP_ORI),
            OPCODE_W'(OP_ANDI),
            OPCODE_W'(OP_SLTI),
            OPCODE_W'(OP_LI):   opclass = CL_I;
            OPCODE_W'(OP_LWI),
            OPCODE_W'(OP_SWI):  opclass = CL_MEM;
            default:            opclass = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FSM sequencing FETCH/DECODE/execute states,
// combinational control decode of state and opcode, retired-instruction count.
// Optional build macro MC_STALL_EN: FETCH, MEM_RD and MEM_WR wait for
// mem_ready; without it mem_ready is ignored.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4,
    parameter int CNT_W    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t              state_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [OPCODE_W-1:0] opcode;
    opclass_t            opclass;
    logic                is_lwi;
    logic                is_li;
    logic                is_beq;
    logic                mem_ok;
    ctrl_t               ctrl_c;
    ctrl_t               ctrl_q;
    logic [3:0]          aluop_c;

    assign opcode = bus.OPcode;
    assign is_lwi = (opcode == OPCODE_W'(OP_LWI));
    assign is_li  = (opcode == OPCODE_W'(OP_LI));
    assign is_beq = (opcode == OPCODE_W'(OP_BEQ));

`ifdef MC_STALL_EN
    assign mem_ok = bus.mem_ready;
`else
    // Memory is assumed single-cycle; mem_ready has no effect
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ok = 1'b1;
`endif

    mc_opclass #(.OPCODE_W(OPCODE_W)) u_opclass (
        .opcode  (opcode),
        .opclass (opclass)
    );

    // State sequencing and retired-instruction counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_FETCH;
            count_reg <= '0;
        end else begin
            if (ctrl_c.instr_done) begin
                count_reg <= count_reg + CNT_W'(1);
            end
            case (state_reg)
                ST_FETCH:    if (mem_ok) state_reg <= ST_DECODE;
                ST_DECODE: begin
                    case (opclass)
                        CL_R:    state_reg <= ST_EXEC_R;
                        CL_I:    state_reg <= ST_EXEC_I;
                        CL_MEM:  state_reg <= ST_MEM_ADDR;
                        CL_BR:   state_reg <= ST_BRANCH;
                        CL_J:    state_reg <= ST_JUMP;
                        default: state_reg <= ST_TRAP;
                    endcase
                end
                ST_EXEC_R,
                ST_EXEC_I:   state_reg <= ST_ALU_WB;
                ST_MEM_ADDR: state_reg <= is_lwi ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   if (mem_ok) state_reg <= ST_MEM_WB;
                ST_MEM_WR:   if (mem_ok) state_reg <= ST_FETCH;
                ST_TRAP:     state_reg <= ST_TRAP;
                default:     state_reg <= ST_FETCH;
            endcase
        end
    end

    // Control decode: anything a state does not drive stays 0
    always_comb begin
        ctrl_c  = '0;
        aluop_c = ALU_MOV;
        case (state_reg)
            ST_FETCH: begin
                ctrl_c.memread = 1'b1;
                ctrl_c.irwrite = mem_ok;
                ctrl_c.pcwrite = mem_ok;
                ctrl_c.alusrcb = SRCB_ONE;
                ctrl_c.pcsrc   = PCSRC_ALU;
                aluop_c        = ALU_ADD;
            end
            ST_DECODE: begin
                ctrl_c.alusrcb = SRCB_BROFF;
                aluop_c        = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_REGB;
                aluop_c        = opcode[3:0];
            end
            ST_EXEC_I: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_IMM;
                aluop_c        = is_li ? ALU_MOV : opcode[3:0];
            end
            ST_ALU_WB: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.regdst     = (opclass == CL_R);
                ctrl_c.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl_c.alusrcb = SRCB_IMM;
                aluop_c        = ALU_MOV;
            end
            ST_MEM_RD: begin
                ctrl_c.memread = 1'b1;
                ctrl_c.iord    = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.memtoreg   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_c.memwrite   = 1'b1;
                ctrl_c.iord       = 1'b1;
                ctrl_c.instr_done = mem_ok;
            end
            ST_BRANCH: begin
                ctrl_c.alusrca     = 1'b1;
                ctrl_c.alusrcb     = SRCB_REGB;
                ctrl_c.pcwritecond = 1'b1;
                ctrl_c.pcsrc       = PCSRC_ALUOUT;
                ctrl_c.beq         = is_beq;
                ctrl_c.instr_done  = 1'b1;
                aluop_c            = ALU_SUB;
            end
            ST_JUMP: begin
                ctrl_c.pcwrite    = 1'b1;
                ctrl_c.pcsrc      = PCSRC_JUMP;
                ctrl_c.instr_done = 1'b1;
            end
            ST_TRAP: begin
                ctrl_c.illegal = 1'b1;
            end
            default: begin
                ctrl_c = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of the clock
    assign ctrl_q = reset ? ctrl_c : '0;

    assign bus.PCWriteCond = ctrl_q.pcwritecond;
    assign bus.PCWrite     = ctrl_q.pcwrite;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.memread;
    assign bus.MemWrite    = ctrl_q.memwrite;
    assign bus.MemtoReg    = ctrl_q.memtoreg;
    assign bus.IRWrite     = ctrl_q.irwrite;
    assign bus.BEQ         = ctrl_q.beq;
    assign bus.ALUSrcA     = ctrl_q.alusrca;
    assign bus.RegWrite    = ctrl_q.regwrite;
    assign bus.RegDst      = ctrl_q.regdst;
    assign bus.PCSrc       = ctrl_q.pcsrc;
    assign bus.ALUSrcB     = ctrl_q.alusrcb;
    assign bus.illegal     = ctrl_q.illegal;
    assign bus.instr_done  = ctrl_q.instr_done;
    assign bus.ALUOP       = reset ? ALUOP_W'(aluop_c) : '0;
    assign bus.state       = state_reg;
    assign bus.instr_count = count_reg;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, opcode width (values below 6 not supported).
REQ-002 SHALL have parameter ALUOP_W, default 4, ALU operation code width.
REQ-003 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 OPcode  in  OPCODE_W  instruction opcode from IR, stable from end of FETCH until the next FETCH.
REQ-007 mem_ready  in  1  memory-access complete (used only with MC_STALL_EN).
REQ-008 PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, BEQ, ALUSrcA, RegWrite, RegDst  out  1 each  datapath control strobes.
REQ-009 PCSrc  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target.
REQ-010 ALUOP  out  ALUOP_W  ALU operation.
REQ-011 ALUSrcB  out  2  0=reg B, 1=constant 1, 2=sign-extended imm, 3=branch offset.
REQ-012 state  out  4  current FSM state code.
REQ-013 illegal  out  1  high while in TRAP.
REQ-014 instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-015 instr_count  out  CNT_W  retired instructions, wraps to 0 after all-ones.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, TRAP=11.
REQ-017 Opcodes: j=1; R-type mov 16, not 17, add 18, sub 19, or 20, and 21, slt 23; beq 32, bne 33; I-type addi 50, subi 51, ori 52, andi 53, slti 55, li 57; lwi 59, swi 60; all others illegal.
REQ-018 FETCH: MemRead=1, IRWrite=1, PCWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOP=ALU_ADD, PCSrc=0; next DECODE.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=3, ALUOP=ALU_ADD; next EXEC_R / EXEC_I / MEM_ADDR (lwi, swi) / BRANCH / JUMP / TRAP by opcode class.
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOP=OPcode[3:0]; EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOP=OPcode[3:0] except li uses ALU_MOV; both next ALU_WB.
REQ-021 ALU_WB: RegWrite=1, MemtoReg=0, RegDst=1 for R-type, 0 for I-type; instr_done=1; next FETCH.
REQ-022 MEM_ADDR: ALUSrcB=2, ALUOP=ALU_MOV; next MEM_RD (lwi) or MEM_WR (swi).
REQ-023 MEM_RD: MemRead=1, IorD=1; next MEM_WB. MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; next FETCH.
REQ-024 MEM_WR: MemWrite=1, IorD=1, instr_done=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOP=ALU_SUB, PCWriteCond=1, PCSrc=1, BEQ=1 for beq, 0 for bne; instr_done=1; next FETCH.
REQ-026 JUMP: PCWrite=1, PCSrc=2, instr_done=1; next FETCH.
REQ-027 TRAP: all strobes 0, illegal=1, instr_done=0; remains until reset.
REQ-028 Any control output not listed for a state SHALL be 0; outputs are a combinational decode of state and OPcode.
REQ-029 Latency without stalls: R/I-type 4 cycles, lwi 5, swi 4, beq/bne 3, j 3.
REQ-030 instr_count SHALL increment by 1 on each clock edge where instr_done=1.

Reset
REQ-031 While reset=0: state=FETCH, instr_count=0, every output 0 (including FETCH strobes), regardless of clock.
REQ-032 Reset asserted mid-instruction SHALL abandon it without incrementing instr_count; first cycle after release is FETCH.

Configuration
REQ-033 With MC_STALL_EN defined, FETCH, MEM_RD and MEM_WR SHALL hold (outputs unchanged; PCWrite and IRWrite gated to 0 until mem_ready=1) and advance only on a cycle with mem_ready=1; instr_done in MEM_WR only on that cycle.
REQ-034 Without MC_STALL_EN, mem_ready SHALL be ignored and those states last exactly one cycle.

Structure
REQ-035 Shared package mc_pkg SHALL hold state codes, opcode constants, ALU codes (ALU_MOV=0, NOT=1, ADD=2, SUB=3, OR=4, AND=5, SLT=7) and PCSrc/ALUSrcB encodings.
REQ-036 Opcode classification SHALL be sub-module mc_opclass (OPcode -> class R/I/MEM/BR/J/ILLEGAL), purely combinational.

Verification
REQ-037 Reset low, then release, OPcode=18 -> states 0,1,2,4,0; ALUOP=2 in EXEC_R; RegWrite=1, RegDst=1 in ALU_WB; instr_count=1.
REQ-038 OPcode=59 -> states 0,1,5,6,7,0; MemtoReg=1 in MEM_WB; OPcode=60 -> MemWrite=1 in state 8 only.
REQ-039 OPcode=33 -> states 0,1,9,0 with PCWriteCond=1, BEQ=0, PCSrc=1; OPcode=1 -> state 10 with PCSrc=2, PCWrite=1.
REQ-040 OPcode=22 -> TRAP, illegal=1, stays 10 cycles, instr_count unchanged; reset clears.
REQ-041 MC_STALL_EN, lwi, mem_ready=0 for 3 cycles in MEM_RD -> state 6 held 4 cycles, total latency 8.
REQ-042 instr_count preset near wrap (CNT_W=4, 15 instructions then one more) -> wraps to 0; reset in EXEC_I -> outputs 0 immediately, count unchanged.
